// File: rtl/gonso_io_sequencer.sv
// Wishbone-programmed byte sequencer: firmware fills a FIFO, bytes replay on io_out at a DIV+1 cycle rate.
// Optional drain interrupt enabled by defining SEQ_IRQ_EN.
module gonso_io_sequencer #(
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter int          DEPTH    = 8,
  parameter int          DIV_W    = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [7:0]  io_out,
  output logic [7:0]  io_oeb,
  output logic        irq
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic             en, loop, ovf, irq_bit;
  logic [DIV_W-1:0] div, cnt;
  logic [7:0]       mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [CW-1:0]    count, count_nxt, occ;
  logic             hit, wr_ctrl, wr_div, wr_data, wr_stat, flush;
  logic             tick, repush, push_ok, push_drop;
  logic [1:0]       off;
  logic [7:0]       head;
  logic [31:0]      rd_val;
  logic             unused_bits;

  assign off     = wbs_adr_i[3:2];
  assign hit     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADR[31:4]) & ~wbs_ack_o;
  assign wr_ctrl = hit & wbs_we_i & (off == 2'd0);
  assign wr_div  = hit & wbs_we_i & (off == 2'd1);
  assign wr_data = hit & wbs_we_i & (off == 2'd2) & wbs_sel_i[0];
  assign wr_stat = hit & wbs_we_i & (off == 2'd3);
  assign flush   = wr_ctrl & wbs_dat_i[2];

  assign tick    = en & (count != '0) & (cnt == div);
  assign repush  = tick & loop;
  assign head    = mem[rptr];

  // Occupancy after the playout pop/re-push; a bus push needs a free slot beyond that.
  assign occ       = count - CW'(tick) + CW'(repush);
  assign push_ok   = wr_data & (occ < FULL_CNT);
  assign push_drop = wr_data & ~push_ok;
  assign count_nxt = flush ? '0 : occ + CW'(push_ok);

  assign unused_bits = ^{wbs_sel_i[3:1], wbs_adr_i[1:0], wbs_dat_i};

  always_comb begin
    rd_val = '0;
    case (off)
      2'd0:    rd_val[1:0] = {loop, en};
      2'd1:    rd_val      = 32'(div);
      2'd2:    rd_val      = '0;
      default: begin
        rd_val[6:0] = 7'(count);
        rd_val[8]   = (count == '0);
        rd_val[9]   = (count == FULL_CNT);
        rd_val[10]  = ovf;
        rd_val[11]  = irq_bit;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= hit;
      wbs_dat_o <= (hit & ~wbs_we_i) ? rd_val : '0;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      en   <= 1'b0;
      loop <= 1'b0;
      div  <= '0;
      ovf  <= 1'b0;
    end else begin
      if (wr_ctrl) {loop, en} <= wbs_dat_i[1:0];
      if (wr_div) div <= wbs_dat_i[DIV_W-1:0];
      if (push_drop) ovf <= 1'b1;
      else if (wr_stat & wbs_dat_i[10]) ovf <= 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      count <= count_nxt;
      if (flush) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        wptr <= wptr + AW'(repush) + AW'(push_ok);
        rptr <= rptr + AW'(tick);
      end
    end
  end

  // The re-pushed byte lands first, so a same-cycle bus byte queues behind it.
  always_ff @(posedge wb_clk_i) begin
    if (repush) mem[wptr] <= head;
    if (push_ok) mem[repush ? wptr + AW'(1) : wptr] <= wbs_dat_i[7:0];
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cnt    <= '0;
      io_out <= '0;
      io_oeb <= 8'hFF;
    end else begin
      io_oeb <= {8{~en}};
      if (tick) io_out <= head;
      if (!en || count == '0 || wr_div || tick) cnt <= '0;
      else cnt <= cnt + DIV_W'(1);
    end
  end

`ifdef SEQ_IRQ_EN
  logic drain;
  assign drain = tick & (count == CW'(1)) & (count_nxt == '0);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) irq <= 1'b0;
    else if (drain) irq <= 1'b1;
    else if (wr_stat) irq <= 1'b0;
  end
  assign irq_bit = irq;
`else
  assign irq     = 1'b0;
  assign irq_bit = 1'b0;
`endif

endmodule
